// File: rtl/uart_mem_responder_if.sv
// UART link pins between a memory initiator and the responder.
// Pure wiring, no latency.
// No backpressure: the protocol is half-duplex and paced by the initiator.
interface uart_mem_responder_if;
    logic rx_i;
    logic tx_o;
    logic busy_o;
    logic frame_err_o;

    // Initiator side: drives the request line, observes response and status
    modport master (
        output rx_i,
        input  tx_o,
        input  busy_o,
        input  frame_err_o
    );

    // Responder side
    modport slave (
        input  rx_i,
        output tx_o,
        output busy_o,
        output frame_err_o
    );
endinterface

// File: rtl/uart_mem_responder.sv
// UART memory server: 8N1 read/write request frames in, response frames out, internal word RAM.
// Latency: response start bit within 3 cycles of the final request stop-bit sample.
// No backpressure: bytes arriving while executing/responding are dropped with a frame_err_o pulse.
module uart_mem_responder #(
    parameter int CLKS_PER_BIT = 16,
    parameter int MEM_WORDS    = 1024,
    parameter int TIMEOUT_CLKS = 40 * CLKS_PER_BIT
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    uart_mem_responder_if.slave  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int GW = $clog2(TIMEOUT_CLKS + 1);
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CLKS - 1);
    localparam logic [29:0]   DEPTH    = 30'(MEM_WORDS);
    localparam logic [7:0]    CMD_RD   = 8'h52;
    localparam logic [7:0]    CMD_WR   = 8'h57;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_ADDR, P_WDATA, P_STRB, P_EXEC, P_RESP} p_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // ---------------- receiver ----------------
    logic          rx_s1, rx_s2, rx_d;
    rx_state_t     rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_valid, rx_stop_err;

    // Two-stage synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= bus.rx_i;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // Receiver state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // Receiver next state: start-bit recheck at half bit, mid-bit sampling, stop validation
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt + 1'b1;
        rx_bit_n    = rx_bit;
        rx_shift_n  = rx_shift;
        rx_valid    = 1'b0;
        rx_stop_err = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_d && !rx_s2) rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_cnt == BIT_HALF) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                    if (rx_s2) rx_valid    = 1'b1;
                    else       rx_stop_err = 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // ---------------- parser ----------------
    p_state_t      p_state, p_state_n;
    logic [1:0]    p_bcnt, p_bcnt_n;
    logic          is_wr, is_wr_n;
    logic [29:0]   idx, idx_n;
    logic [31:0]   wdata, wdata_n;
    logic [3:0]    strb, strb_n;
    logic [GW-1:0] gap, gap_n;
    logic          p_err;
    logic          in_frame;
    logic          in_range;
    logic          tx_done;
    logic [31:0]   rd_q;
    logic [31:0]   resp_word;
    logic          busy_q, frame_err_q;

    assign in_frame  = (p_state == P_ADDR) || (p_state == P_WDATA) || (p_state == P_STRB);
    assign in_range  = (idx < DEPTH);
    assign resp_word = is_wr ? 32'h0000_0006 : (in_range ? rd_q : 32'hDEAD_BEEF);

    // Parser state register plus busy/error output flops
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            p_state     <= P_IDLE;
            p_bcnt      <= '0;
            is_wr       <= 1'b0;
            idx         <= '0;
            wdata       <= '0;
            strb        <= '0;
            gap         <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            p_state     <= p_state_n;
            p_bcnt      <= p_bcnt_n;
            is_wr       <= is_wr_n;
            idx         <= idx_n;
            wdata       <= wdata_n;
            strb        <= strb_n;
            gap         <= gap_n;
            busy_q      <= (p_state_n != P_IDLE);
            frame_err_q <= rx_stop_err | p_err;
        end
    end

    // Parser next state: collect fields, police inter-byte gap, reject bytes while busy
    always_comb begin
        p_state_n = p_state;
        p_bcnt_n  = p_bcnt;
        is_wr_n   = is_wr;
        idx_n     = idx;
        wdata_n   = wdata;
        strb_n    = strb;
        gap_n     = '0;
        p_err     = 1'b0;
        if (in_frame && !rx_valid) begin
            if (gap == GAP_LAST) begin
                p_err     = 1'b1;
                p_state_n = P_IDLE;
            end else begin
                gap_n = gap + 1'b1;
            end
        end
        unique case (p_state)
            P_IDLE: begin
                if (rx_valid) begin
                    p_bcnt_n = '0;
                    if (rx_shift == CMD_RD) begin
                        is_wr_n   = 1'b0;
                        p_state_n = P_ADDR;
                    end else if (rx_shift == CMD_WR) begin
                        is_wr_n   = 1'b1;
                        p_state_n = P_ADDR;
                    end else begin
                        p_err = 1'b1;
                    end
                end
            end
            P_ADDR: begin
                if (rx_valid) begin
                    p_bcnt_n = p_bcnt + 1'b1;
                    // Address bits [1:0] are dropped: only the word index is kept
                    unique case (p_bcnt)
                        2'd0: idx_n[5:0]   = rx_shift[7:2];
                        2'd1: idx_n[13:6]  = rx_shift;
                        2'd2: idx_n[21:14] = rx_shift;
                        2'd3: idx_n[29:22] = rx_shift;
                    endcase
                    if (p_bcnt == 2'd3) p_state_n = is_wr ? P_WDATA : P_EXEC;
                end
            end
            P_WDATA: begin
                if (rx_valid) begin
                    p_bcnt_n = p_bcnt + 1'b1;
                    wdata_n  = {rx_shift, wdata[31:8]};
                    if (p_bcnt == 2'd3) p_state_n = P_STRB;
                end
            end
            P_STRB: begin
                if (rx_valid) begin
                    strb_n    = rx_shift[3:0];
                    p_state_n = P_EXEC;
                end
            end
            P_EXEC: begin
                if (rx_valid) p_err = 1'b1;
                p_state_n = P_RESP;
            end
            P_RESP: begin
                if (rx_valid) p_err = 1'b1;
                if (tx_done) p_state_n = P_IDLE;
            end
            default: p_state_n = P_IDLE;
        endcase
    end

    // ---------------- memory ----------------
    logic [31:0] mem [MEM_WORDS];
    logic        mem_we, mem_re;

    assign mem_we = rst_ni && (p_state == P_EXEC) && is_wr && in_range;
    assign mem_re = (p_state == P_EXEC) && !is_wr;

    // Byte-masked write and registered read; contents survive reset
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) mem[idx[AW-1:0]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (mem_re) rd_q <= mem[idx[AW-1:0]];
    end

    // ---------------- transmitter ----------------
    tx_state_t     tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_sh, tx_sh_n;
    logic [23:0]   tx_rest, tx_rest_n;
    logic [1:0]    tx_left, tx_left_n;
    logic          tx_q, tx_n;
    logic          tx_go;

    // The first P_RESP cycle is the one where the read data has just landed in rd_q
    assign tx_go = (p_state == P_RESP) && (tx_state == TX_IDLE);

    // Transmitter state register; line output is a flop so tx_o never glitches
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_rest  <= '0;
            tx_left  <= '0;
            tx_q     <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            tx_rest  <= tx_rest_n;
            tx_left  <= tx_left_n;
            tx_q     <= tx_n;
        end
    end

    // Transmitter next state: response bytes chained stop-to-start with no idle gap
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 1'b1;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_rest_n  = tx_rest;
        tx_left_n  = tx_left;
        tx_done    = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (tx_go) begin
                    tx_sh_n    = resp_word[7:0];
                    tx_rest_n  = resp_word[31:8];
                    tx_left_n  = is_wr ? 2'd0 : 2'd3;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    tx_bit_n = tx_bit + 1'b1;
                    tx_sh_n  = {1'b0, tx_sh[7:1]};
                    if (tx_bit == 3'd7) tx_state_n = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_left != 2'd0) begin
                        tx_sh_n    = tx_rest[7:0];
                        tx_rest_n  = {8'h00, tx_rest[23:8]};
                        tx_left_n  = tx_left - 1'b1;
                        tx_state_n = TX_START;
                    end else begin
                        tx_state_n = TX_IDLE;
                        tx_done    = 1'b1;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        tx_n = (tx_state_n == TX_START) ? 1'b0 :
               (tx_state_n == TX_DATA)  ? tx_sh_n[0] : 1'b1;
    end

    assign bus.tx_o        = tx_q;
    assign bus.busy_o      = busy_q;
    assign bus.frame_err_o = frame_err_q;
endmodule
